// File: rtl/pin_sender.sv
// PIN sender: shows a card to the teller, sends a 3-digit code framed by a zero separator,
// waits for cash/destroy response. Optional retry on timeout: define PIN_SENDER_RETRY_EN.
module pin_sender #(
  parameter int HOLD    = 1,
  parameter int TIMEOUT = 8,
  parameter int MAX_TRY = 3
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] dig0,
  input  logic [2:0] dig1,
  input  logic [2:0] dig2,
  input  logic       dinheiro,
  input  logic       destroi,
  output logic       cartao,
  output logic [2:0] cod,
  output logic       busy,
  output logic       done,
  output logic       ok,
  output logic       fail,
  output logic       err,
  output logic [1:0] tries,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_D0, S_D1, S_D2, S_WAIT, S_END
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
`ifdef PIN_SENDER_RETRY_EN
  localparam logic [1:0] TRY_LIMIT = 2'(MAX_TRY);
`else
  // Single attempt, still bounded by MAX_TRY.
  localparam logic [1:0] TRY_LIMIT = 2'((MAX_TRY < 1) ? MAX_TRY : 1);
`endif

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] tries_q, tries_d;
  logic [2:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic       cartao_q, cartao_d;
  logic [2:0] cod_q, cod_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ok_q, ok_d, fail_q, fail_d, err_q, err_d;
  logic       code_legal;
  logic       in_send;

  assign code_legal = (dig0 != 3'd0) && (dig1 != dig0) && (dig2 != dig1);
  assign in_send    = (state_q == S_SYNC) || (state_q == S_D0) || (state_q == S_D1) ||
                      (state_q == S_D2) || (state_q == S_WAIT);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    tries_d = tries_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    ok_d    = ok_q;
    fail_d  = fail_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (in_send && abort) begin
      // Abort beats any response arriving in the same cycle.
      state_d = S_IDLE;
      fail_d  = 1'b1;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (code_legal) begin
              d0_d    = dig0;
              d1_d    = dig1;
              d2_d    = dig2;
              ok_d    = 1'b0;
              fail_d  = 1'b0;
              err_d   = 1'b0;
              tries_d = 2'd1;
              hold_d  = '0;
              state_d = S_SYNC;
            end else begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end
          end
        end
        S_SYNC, S_D0, S_D1, S_D2: begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            case (state_q)
              S_SYNC:  state_d = S_D0;
              S_D0:    state_d = S_D1;
              S_D1:    state_d = S_D2;
              default: begin
                state_d = S_WAIT;
                wait_d  = '0;
              end
            endcase
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
        S_WAIT: begin
          if (destroi) begin
            fail_d  = 1'b1;
            state_d = S_END;
          end else if (dinheiro) begin
            ok_d    = 1'b1;
            state_d = S_END;
          end else if (wait_q == WAIT_LAST) begin
`ifdef PIN_SENDER_RETRY_EN
            if (tries_q < TRY_LIMIT) begin
              tries_d = tries_q + 2'd1;
              hold_d  = '0;
              state_d = S_SYNC;
            end else begin
              fail_d  = 1'b1;
              state_d = S_END;
            end
`else
            fail_d  = 1'b1;
            state_d = S_END;
`endif
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        S_END:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d == S_END) done_d = 1'b1;
    // Registered outputs follow the state being entered.
    busy_d   = (state_d != S_IDLE);
    cartao_d = (state_d != S_IDLE) && (state_d != S_END);
    case (state_d)
      S_D0:         cod_d = d0_d;
      S_D1:         cod_d = d1_d;
      S_D2, S_WAIT: cod_d = d2_d;
      default:      cod_d = 3'd0;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      wait_q   <= '0;
      tries_q  <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      cartao_q <= 1'b0;
      cod_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wait_q   <= wait_d;
      tries_q  <= tries_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      cartao_q <= cartao_d;
      cod_q    <= cod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
    end
  end

  assign cartao      = cartao_q;
  assign cod         = cod_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ok          = ok_q;
  assign fail        = fail_q;
  assign err         = err_q;
  assign tries       = tries_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pin_sender.sv
// Bench for pin_sender: per-session expected output trace is queued by the driver and
// popped by a monitor on every cycle the DUT shows busy or done.
module tb_pin_sender;
  localparam int HOLD    = 1;
  localparam int TIMEOUT = 8;
  localparam int MAX_TRY = 3;
`ifdef PIN_SENDER_RETRY_EN
  localparam int N_ATT = MAX_TRY;
`else
  localparam int N_ATT = 1;
`endif

  logic       clk_2, reset, start, abort, dinheiro, destroi;
  logic [2:0] dig0, dig1, dig2;
  logic       cartao, busy, done, ok, fail, err;
  logic [2:0] cod;
  logic [1:0] tries;
  logic [2:0] dbg_state;

  // {busy, cartao, cod[2:0], done, ok, fail, err, tries[1:0]}
  logic [10:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic       l_ok, l_fail, l_err;
  logic [1:0] l_tries;

  pin_sender #(.HOLD(HOLD), .TIMEOUT(TIMEOUT), .MAX_TRY(MAX_TRY)) dut (
    .clk_2(clk_2), .reset(reset), .start(start), .abort(abort),
    .dig0(dig0), .dig1(dig1), .dig2(dig2),
    .dinheiro(dinheiro), .destroi(destroi),
    .cartao(cartao), .cod(cod), .busy(busy), .done(done),
    .ok(ok), .fail(fail), .err(err), .tries(tries), .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1);
  end

  function automatic logic [10:0] mk(input logic b, input logic c, input logic [2:0] cd,
                                      input logic dn, input logic o, input logic f,
                                      input logic e, input logic [1:0] t);
    return {b, c, cd, dn, o, f, e, t};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input logic o, input logic f, input logic e, input logic [1:0] t);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_card", 32'({cartao, cod}), 32'd0);
    check("idle_flags", 32'({ok, fail, err, tries}), 32'({o, f, e, t}));
  endtask

  // Scoreboard monitor
  always @(negedge clk_2) begin
    logic [10:0] obs, e;
    if (!reset && (busy || done)) begin
      obs = {busy, cartao, cod, done, ok, fail, err, tries};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %0h want nothing", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          bad++;
          $display("FAIL trace {busy,cartao,cod,done,ok,fail,err,tries}: got %b want %b", obs, e);
        end
      end
    end
  end

  // kind: 0 no response, 1 dinheiro, 2 destroi, 3 both; att/rw locate the response.
  task automatic run_session(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                             input int kind, input int att, input int rw,
                             input int abort_idx, input int reset_idx);
    logic [10:0] tr[$];
    logic [2:0]  inp[$];
    logic [2:0]  vals[4];
    logic        ended, fo, ff;
    logic [1:0]  ft;
    int          n;
    dig0 = a0; dig1 = a1; dig2 = a2;
    if (!(a0 != 3'd0 && a1 != a0 && a2 != a1)) begin
      exp_q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, l_ok, l_fail, 1'b1, l_tries));
      start = 1'b1;
      @(posedge clk_2); #1;
      start = 1'b0;
      @(posedge clk_2); #1;
      l_err = 1'b1;
      check_idle(l_ok, l_fail, l_err, l_tries);
      return;
    end
    vals[0] = 3'd0; vals[1] = a0; vals[2] = a1; vals[3] = a2;
    ended = 1'b0; fo = 1'b0; ff = 1'b0; ft = 2'd0;
    for (int a = 1; a <= N_ATT && !ended; a++) begin
      for (int v = 0; v < 4; v++)
        for (int h = 0; h < HOLD; h++) begin
          tr.push_back(mk(1'b1, 1'b1, vals[v], 1'b0, 1'b0, 1'b0, 1'b0, 2'(a)));
          inp.push_back(3'b000);
        end
      for (int w = 0; w < TIMEOUT && !ended; w++) begin
        tr.push_back(mk(1'b1, 1'b1, a2, 1'b0, 1'b0, 1'b0, 1'b0, 2'(a)));
        if (kind != 0 && a == att && w == rw) begin
          ended = 1'b1;
          inp.push_back({1'b0, kind[1], kind[0]});
          fo = (kind == 1);
          ff = (kind != 1);
          ft = 2'(a);
        end else begin
          inp.push_back(3'b000);
        end
      end
    end
    if (!ended) begin
      ff = 1'b1;
      ft = 2'(N_ATT);
    end
    tr.push_back(mk(1'b1, 1'b0, 3'd0, 1'b1, fo, ff, 1'b0, ft));
    inp.push_back(3'b000);
    if (abort_idx >= 0 && abort_idx < tr.size() - 1) begin
      ft = tr[abort_idx][1:0];
      while (tr.size() > abort_idx + 1) begin
        void'(tr.pop_back());
        void'(inp.pop_back());
      end
      inp[abort_idx][2] = 1'b1;
      tr.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, ft));
      inp.push_back(3'b000);
      fo = 1'b0;
      ff = 1'b1;
    end
    n = tr.size();
    if (reset_idx >= 0 && reset_idx < n) n = reset_idx;
    else reset_idx = -1;
    for (int i = 0; i < n; i++) exp_q.push_back(tr[i]);

    start = 1'b1;
    @(posedge clk_2); #1;
    start = 1'b0;
    for (int i = 0; i < tr.size(); i++) begin
      dinheiro = inp[i][0];
      destroi  = inp[i][1];
      abort    = inp[i][2];
      dig0 = 3'($urandom_range(0, 7));
      dig1 = 3'($urandom_range(0, 7));
      dig2 = 3'($urandom_range(0, 7));
      start = tr[i][10] ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == reset_idx) begin
        reset = 1'b1;
        abort = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        @(posedge clk_2); #1;
        reset = 1'b0; start = 1'b0; abort = 1'b0; dinheiro = 1'b0; destroi = 1'b0;
        exp_q.delete();
        l_ok = 1'b0; l_fail = 1'b0; l_err = 1'b0; l_tries = 2'd0;
        check_idle(1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clk_2); #1;
        check("reset_no_done", 32'(done), 32'd0);
        return;
      end
      @(posedge clk_2); #1;
    end
    start = 1'b0; abort = 1'b0; dinheiro = 1'b0; destroi = 1'b0;
    l_ok = fo; l_fail = ff; l_err = 1'b0; l_tries = ft;
    check_idle(l_ok, l_fail, l_err, l_tries);
  endtask

  initial begin
    logic [2:0] r0, r1, r2;
    reset = 1'b1; start = 1'b0; abort = 1'b0; dinheiro = 1'b0; destroi = 1'b0;
    dig0 = 3'd0; dig1 = 3'd0; dig2 = 3'd0;
    l_ok = 1'b0; l_fail = 1'b0; l_err = 1'b0; l_tries = 2'd0;
    repeat (3) @(posedge clk_2);
    #1;
    reset = 1'b0;
    check_idle(1'b0, 1'b0, 1'b0, 2'd0);

    run_session(3'd1, 3'd3, 3'd7, 1, 1, 1, -1, -1);            // cash on 2nd WAIT cycle
    run_session(3'd1, 3'd3, 3'd3, 0, 1, 0, -1, -1);            // illegal code
    run_session(3'd2, 3'd5, 3'd1, 0, 1, 0, -1, -1);            // never answered
    run_session(3'd4, 3'd6, 3'd2, 3, 1, 3, -1, -1);            // both responses
    run_session(3'd5, 3'd0, 3'd6, 0, 1, 0, 2 * HOLD, -1);      // abort in D1
    run_session(3'd3, 3'd1, 3'd4, 0, 1, 0, -1, 4 * HOLD + 2);  // reset in WAIT
    run_session(3'd1, 3'd3, 3'd7, 2, 1, 0, -1, -1);            // destroyed
    run_session(3'd6, 3'd7, 3'd0, 1, 2, TIMEOUT - 1, -1, -1);  // cash on 2nd attempt
    run_session(3'd0, 3'd1, 3'd2, 0, 1, 0, -1, -1);            // zero first digit
    run_session(3'd7, 3'd2, 3'd2, 0, 1, 0, -1, -1);            // repeated digit

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        r0 = 3'($urandom_range(1, 7));
        do r1 = 3'($urandom_range(0, 7)); while (r1 == r0);
        do r2 = 3'($urandom_range(0, 7)); while (r2 == r1);
      end else begin
        r0 = 3'($urandom_range(0, 7));
        r1 = 3'($urandom_range(0, 7));
        r2 = 3'($urandom_range(0, 7));
      end
      run_session(r0, r1, r2, int'($urandom_range(0, 3)), int'($urandom_range(1, MAX_TRY)),
                  int'($urandom_range(0, TIMEOUT - 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 * HOLD + TIMEOUT)) : -1,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    repeat (2) @(posedge clk_2);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pin_sender.md
PIN_SENDER -- requirements
Module: pin_sender

Interface
REQ-001 Parameter HOLD, default 1: clock cycles each value (separator or digit) SHALL be held on cod; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 8: cycles SHALL be waited in WAIT for a response before an attempt counts as failed; legal range 1..255.
REQ-003 Parameter MAX_TRY, default 3: maximum attempts per session; legal range 1..3.
REQ-004 Port clk_2  input  1: the only clock; all logic SHALL be rising-edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port start  input  1: request a session, sampled only in IDLE.
REQ-007 Port abort  input  1: cancel the current session.
REQ-008 Port dig0, dig1, dig2  input  3 each: code digits, captured on accepted start.
REQ-009 Port dinheiro  input  1: cash-dispensed response from the teller.
REQ-010 Port destroi  input  1: card-destroyed response from the teller.
REQ-011 Port cartao  output  1: card-inserted indication to the teller.
REQ-012 Port cod  output  3: code value bus to the teller.
REQ-013 Port busy  output  1: session in progress.
REQ-014 Port done  output  1: one-cycle end-of-session pulse.
REQ-015 Port ok, fail, err  output  1 each: sticky session result flags.
REQ-016 Port tries  output  2: attempts started in the current or last session.

Function
REQ-017 States SHALL be IDLE, SYNC, D0, D1, D2, WAIT, END; all outputs SHALL be registered.
REQ-018 IDLE: cartao=0, cod=0, busy=0; start=1 with a legal code -> capture digits, clear ok/fail/err, tries=1, go to SYNC.
REQ-019 Legal code: dig0!=0, dig1!=dig0, dig2!=dig1; on start with an illegal code the block SHALL stay in IDLE, set err=1 and pulse done.
REQ-020 SYNC: cartao=1, cod=0 for HOLD cycles, then D0.
REQ-021 D0/D1/D2: cartao=1, cod=captured digit for HOLD cycles each, then the next state; D2 proceeds to WAIT.
REQ-022 WAIT: cartao=1, cod holds dig2; a cycle counter SHALL run from 0.
REQ-023 WAIT, dinheiro=1 -> END with ok=1; destroi=1 -> END with fail=1; if both are high on the same cycle, destroi SHALL win.
REQ-024 WAIT, counter reaching TIMEOUT with no response -> retry per REQ-032/033.
REQ-025 END: done=1 for exactly one cycle, cartao=0, cod=0, then IDLE; ok/fail/err/tries SHALL hold until the next accepted start or reset.
REQ-026 busy SHALL be 1 in SYNC through END.
REQ-027 start while busy SHALL be ignored; digit inputs SHALL be ignored outside the capture cycle.
REQ-028 abort in any busy state -> next cycle IDLE, cartao=0, cod=0, fail=1, done pulsed once; abort has priority over responses.
REQ-029 tries SHALL never exceed MAX_TRY and SHALL not wrap.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE with cartao=0, cod=0, busy=0, done=0, ok=0, fail=0, err=0, tries=0, counters=0.
REQ-031 reset mid-session SHALL discard the session without pulsing done; reset SHALL dominate start and abort.

Configuration
REQ-032 With macro PIN_SENDER_RETRY_EN defined: on timeout with tries<MAX_TRY -> tries+1, return to SYNC; with tries==MAX_TRY -> END with fail=1.
REQ-033 Without PIN_SENDER_RETRY_EN: any timeout SHALL go straight to END with fail=1, tries stays 1; MAX_TRY is unused.

Verification (HOLD=1, TIMEOUT=8, MAX_TRY=3, RETRY enabled unless noted)
REQ-034 start with code 1,3,7 at edge 0 -> cod=0,1,3,7 on cycles 1..4 with cartao=1; dinheiro raised at cycle 6 -> done at cycle 7, ok=1, tries=1.
REQ-035 start with code 1,3,3 -> err=1, done pulse, busy stays 0, cartao stays 0.
REQ-036 No response ever -> three full 0,d0,d1,d2 sequences, tries=1,2,3, then fail=1, done pulse; without the macro only one sequence and then fail=1.
REQ-037 dinheiro and destroi both asserted in the same WAIT cycle -> fail=1, ok=0.
REQ-038 abort during D1 -> next cycle cartao=0, cod=0, fail=1, one done pulse; start during a session has no effect.
REQ-039 reset asserted during WAIT -> next cycle all outputs 0, no done pulse; a subsequent start runs normally.
